// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared opcodes, ALU op codes, FSM states and decode classes
//               for the rv32i_sc multi-cycle control path.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    localparam logic [3:0] c_alu_add       = 4'd0;
    localparam logic [3:0] c_alu_sub       = 4'd1;
    localparam logic [3:0] c_alu_sll       = 4'd2;
    localparam logic [3:0] c_alu_slt       = 4'd3;
    localparam logic [3:0] c_alu_sltu      = 4'd4;
    localparam logic [3:0] c_alu_xor       = 4'd5;
    localparam logic [3:0] c_alu_srl       = 4'd6;
    localparam logic [3:0] c_alu_sra       = 4'd7;
    localparam logic [3:0] c_alu_or        = 4'd8;
    localparam logic [3:0] c_alu_and       = 4'd9;
    localparam logic [3:0] c_alu_slti_cmp  = 4'd10;
    localparam logic [3:0] c_alu_sltiu_cmp = 4'd11;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_OP      = 3'd0,
        CLS_OP_IMM  = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        case (opcode)
            c_opc_op:     return CLS_OP;
            c_opc_op_imm: return CLS_OP_IMM;
            c_opc_load:   return CLS_LOAD;
            c_opc_store:  return CLS_STORE;
            c_opc_branch: return CLS_BRANCH;
            c_opc_jal:    return CLS_JAL;
            default:      return CLS_ILLEGAL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Control bundle between the sequencer (master) and the
//               rv32i_sc datapath / memories (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;

    logic [31:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        alu_zero;
    logic        alu_lsb;
    logic        imem_req;
    logic        ir_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        pc_write;
    logic        pc_sel;
    logic        illegal;

    modport master (
        input  instr, imem_ack, dmem_ack, alu_zero, alu_lsb,
        output imem_req, ir_write, dmem_req, dmem_we, alu_ctrl, alu_src,
               reg_write, wb_sel, pc_write, pc_sel, illegal
    );

    modport slave (
        output instr, imem_ack, dmem_ack, alu_zero, alu_lsb,
        input  imem_req, ir_write, dmem_req, dmem_we, alu_ctrl, alu_src,
               reg_write, wb_sel, pc_write, pc_sel, illegal
    );

endinterface
`default_nettype wire

// File: rtl/alu_sequencer_alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational instruction decode into instruction class,
//               ALU opcode/operand select and branch-condition polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_e o_class,
    output logic [3:0]   o_alu_ctrl,
    output logic         o_alu_src,
    output logic         o_br_use_zero,
    output logic         o_br_invert,
    output logic         o_br_bad
);

    instr_class_e w_class;
    logic [2:0]   w_f3;
    logic         w_f7b5;
    logic         w_unused_bits;

    assign w_class       = classify(i_instr[6:0]);
    assign w_f3          = i_instr[14:12];
    assign w_f7b5        = i_instr[30];
    assign o_class       = w_class;
    assign w_unused_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    always_comb begin
        o_alu_ctrl    = c_alu_add;
        o_alu_src     = 1'b0;
        o_br_use_zero = 1'b0;
        o_br_invert   = 1'b0;
        o_br_bad      = 1'b0;
        case (w_class)
            CLS_OP, CLS_OP_IMM: begin
                o_alu_src = (w_class == CLS_OP_IMM);
                case (w_f3)
                    // funct7[5] on ADDI is immediate data, not a subtract select
                    3'b000:  o_alu_ctrl = (w_class == CLS_OP && w_f7b5) ? c_alu_sub : c_alu_add;
                    3'b001:  o_alu_ctrl = c_alu_sll;
                    3'b010:  o_alu_ctrl = c_alu_slt;
                    3'b011:  o_alu_ctrl = c_alu_sltu;
                    3'b100:  o_alu_ctrl = c_alu_xor;
                    3'b101:  o_alu_ctrl = w_f7b5 ? c_alu_sra : c_alu_srl;
                    3'b110:  o_alu_ctrl = c_alu_or;
                    default: o_alu_ctrl = c_alu_and;
                endcase
            end
            CLS_LOAD, CLS_STORE: begin
                o_alu_src = 1'b1;
            end
            CLS_BRANCH: begin
                // funct3[0] inverts the sense: BNE/BGE/BGEU
                o_br_invert = w_f3[0];
                case (w_f3)
                    3'b000, 3'b001: begin
                        o_alu_ctrl    = c_alu_sub;
                        o_br_use_zero = 1'b1;
                    end
                    3'b100, 3'b101: o_alu_ctrl = c_alu_slti_cmp;
                    3'b110, 3'b111: o_alu_ctrl = c_alu_sltiu_cmp;
                    default:        o_br_bad   = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle control FSM for the rv32i_sc datapath; drives
//               fetch/data handshakes, ALU control, PC update and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.master bus
);

    state_e       r_state;
    state_e       w_next;
    instr_class_e w_class;
    logic [3:0]   w_dec_alu_ctrl;
    logic         w_dec_alu_src;
    logic         w_br_use_zero;
    logic         w_br_invert;
    logic         w_br_bad;
    logic         w_taken;

    logic         w_imem_req;
    logic         w_ir_write;
    logic         w_dmem_req;
    logic         w_dmem_we;
    logic [3:0]   w_alu_ctrl;
    logic         w_alu_src;
    logic         w_reg_write;
    wb_sel_e      w_wb_sel;
    logic         w_pc_write;
    logic         w_pc_sel;

    alu_op_decode u_decode (
        .i_instr       (bus.instr),
        .o_class       (w_class),
        .o_alu_ctrl    (w_dec_alu_ctrl),
        .o_alu_src     (w_dec_alu_src),
        .o_br_use_zero (w_br_use_zero),
        .o_br_invert   (w_br_invert),
        .o_br_bad      (w_br_bad)
    );

    assign w_taken = (w_br_use_zero ? bus.alu_zero : bus.alu_lsb) ^ w_br_invert;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_alu_ctrl  = c_alu_add;
        w_alu_src   = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = WB_ALU;
        w_pc_write  = 1'b0;
        w_pc_sel    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_ir_write = 1'b1;
                    w_next     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = (w_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                w_alu_ctrl = w_dec_alu_ctrl;
                w_alu_src  = w_dec_alu_src;
                case (w_class)
                    CLS_OP, CLS_OP_IMM, CLS_JAL: w_next = ST_WB;
                    CLS_LOAD, CLS_STORE:         w_next = ST_MEM;
                    CLS_BRANCH: begin
                        if (w_br_bad) begin
                            w_next = ST_TRAP;
                        end else begin
                            w_pc_write = 1'b1;
                            w_pc_sel   = w_taken;
                            w_next     = ST_FETCH;
                        end
                    end
                    default: w_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                // address operands stay selected for the whole access
                w_alu_ctrl = w_dec_alu_ctrl;
                w_alu_src  = w_dec_alu_src;
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_class == CLS_STORE);
                if (bus.dmem_ack) begin
                    if (w_class == CLS_STORE) begin
                        w_pc_write = 1'b1;
                        w_next     = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                w_pc_sel    = (w_class == CLS_JAL);
                w_wb_sel    = (w_class == CLS_LOAD) ? WB_LOAD :
                              (w_class == CLS_JAL)  ? WB_PC4  : WB_ALU;
                w_next      = ST_FETCH;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_FETCH;
        endcase
        // reset must silence requests immediately, not at the next edge
        if (rst) begin
            w_imem_req  = 1'b0;
            w_ir_write  = 1'b0;
            w_dmem_req  = 1'b0;
            w_dmem_we   = 1'b0;
            w_alu_ctrl  = c_alu_add;
            w_alu_src   = 1'b0;
            w_reg_write = 1'b0;
            w_wb_sel    = WB_ALU;
            w_pc_write  = 1'b0;
            w_pc_sel    = 1'b0;
        end
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.ir_write  = w_ir_write;
    assign bus.dmem_req  = w_dmem_req;
    assign bus.dmem_we   = w_dmem_we;
    assign bus.alu_ctrl  = w_alu_ctrl;
    assign bus.alu_src   = w_alu_src;
    assign bus.reg_write = w_reg_write;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.pc_write  = w_pc_write;
    assign bus.pc_sel    = w_pc_sel;
    assign bus.illegal   = (r_state == ST_TRAP) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer: random and directed
//               instruction streams against a behavioural instruction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        lsb;
        int          idelay;
        int          ddelay;
    } stim_t;

    typedef struct {
        int         retire_n;
        bit         chk_alu;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       pc_sel;
        int         reg_writes;
        logic [1:0] wb_sel;
        int         dmem_cycles;
        logic       dmem_we;
        int         fetch_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if bus();
    alu_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    stim_t prog[$];
    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t mk(input logic [31:0] w, input logic z, input logic l,
                                 input int id, input int dd);
        stim_t s;
        s.instr = w; s.zero = z; s.lsb = l; s.idelay = id; s.ddelay = dd;
        return s;
    endfunction

    // Expected behaviour of one instruction; returns 1 when it must trap.
    function automatic bit model(input stim_t s, output exp_t e);
        logic [6:0] opc = s.instr[6:0];
        logic [2:0] f3  = s.instr[14:12];
        logic       b30 = s.instr[30];
        logic       cond;
        e = '{default: 0};
        e.fetch_cycles = s.idelay + 1;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            e.retire_n = 4; e.chk_alu = 1; e.reg_writes = 1; e.wb_sel = 0;
            e.alu_src = (opc == 7'b0010011);
            case (f3)
                0: e.alu_ctrl = (opc == 7'b0110011 && b30) ? c_alu_sub : c_alu_add;
                1: e.alu_ctrl = c_alu_sll;
                2: e.alu_ctrl = c_alu_slt;
                3: e.alu_ctrl = c_alu_sltu;
                4: e.alu_ctrl = c_alu_xor;
                5: e.alu_ctrl = b30 ? c_alu_sra : c_alu_srl;
                6: e.alu_ctrl = c_alu_or;
                default: e.alu_ctrl = c_alu_and;
            endcase
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            e.chk_alu = 1; e.alu_ctrl = c_alu_add; e.alu_src = 1;
            e.dmem_cycles = s.ddelay + 1;
            e.dmem_we = (opc == 7'b0100011);
            e.retire_n = e.dmem_we ? 4 + s.ddelay : 5 + s.ddelay;
            e.reg_writes = e.dmem_we ? 0 : 1;
            e.wb_sel = 1;
        end else if (opc == 7'b1100011) begin
            if (f3 == 2 || f3 == 3) return 1'b1;
            e.retire_n = 3; e.chk_alu = 1; e.alu_src = 0;
            e.alu_ctrl = (f3 < 4) ? c_alu_sub : (f3 < 6) ? c_alu_slti_cmp : c_alu_sltiu_cmp;
            cond = (f3 < 4) ? s.zero : s.lsb;
            e.pc_sel = f3[0] ? !cond : cond;
        end else if (opc == 7'b1101111) begin
            e.retire_n = 4; e.reg_writes = 1; e.wb_sel = 2; e.pc_sel = 1;
        end else begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic stim_t rand_stim();
        stim_t      s;
        logic [31:0] w = $urandom;
        int         k  = $urandom_range(0, 5);
        logic       b  = 1'($urandom_range(0, 1));
        int         bf[6] = '{0, 1, 4, 5, 6, 7};
        case (k)
            0: begin w[6:0] = 7'b0110011; w[31:25] = {1'b0, b, 5'b0}; end
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: begin w[6:0] = 7'b1100011; w[14:12] = 3'(bf[$urandom_range(0, 5)]); end
            default: w[6:0] = 7'b1101111;
        endcase
        s.instr  = w;
        s.zero   = 1'($urandom_range(0, 1));
        s.lsb    = 1'($urandom_range(0, 1));
        s.idelay = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
        s.ddelay = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
        return s;
    endfunction

    // Memory/IR responder: acts just after each rising edge, sprinkling spurious acks.
    initial begin : driver
        bit    iarmed = 0;
        bit    darmed = 0;
        int    icnt = 0;
        int    dcnt = 0;
        int    cur_dd = 0;
        stim_t cur;
        exp_t  e;
        bus.instr = '0; bus.imem_ack = 0; bus.dmem_ack = 0; bus.alu_zero = 0; bus.alu_lsb = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                iarmed = 0; darmed = 0; bus.imem_ack = 0; bus.dmem_ack = 0;
                continue;
            end
            if (bus.imem_req) begin
                if (!iarmed && prog.size() > 0) begin
                    cur = prog.pop_front();
                    if (!model(cur, e)) exp_q.push_back(e);
                    iarmed = 1; icnt = cur.idelay;
                end
                if (iarmed && icnt == 0) begin
                    bus.imem_ack = 1; iarmed = 0;
                    bus.instr = cur.instr; bus.alu_zero = cur.zero; bus.alu_lsb = cur.lsb;
                    cur_dd = cur.ddelay;
                end else begin
                    bus.imem_ack = 0;
                    if (iarmed) icnt--;
                end
            end else begin
                bus.imem_ack = ($urandom_range(0, 3) == 0);
            end
            if (bus.dmem_req) begin
                if (!darmed) begin darmed = 1; dcnt = cur_dd; end
                if (dcnt == 0) begin bus.dmem_ack = 1; darmed = 0; end
                else begin bus.dmem_ack = 0; dcnt--; end
            end else begin
                bus.dmem_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin : monitor
        int         n = 0, fetch = 0, regw = 0, dcyc = 0, held_bad = 0;
        bit         active = 0;
        logic [3:0] ac = '0;
        logic       asrc = 0, dwe = 0;
        logic [1:0] wbs = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; n = 0; fetch = 0; exp_q.delete();
                continue;
            end
            if (bus.imem_req) fetch++;
            if (bus.ir_write) begin
                active = 1; n = 1; regw = 0; dcyc = 0; held_bad = 0; wbs = '0; dwe = 0;
            end else if (active) begin
                n++;
            end
            if (active && n == 3) begin ac = bus.alu_ctrl; asrc = bus.alu_src; end
            if (bus.dmem_req) begin
                dcyc++; dwe = bus.dmem_we;
                if (bus.alu_ctrl !== ac || bus.alu_src !== asrc) held_bad++;
            end
            if (bus.reg_write) begin regw++; wbs = bus.wb_sel; end
            if (bus.pc_write) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_retire actual=pc_write required=none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_cycles", n, e.retire_n);
                    chk("fetch_cycles", fetch, e.fetch_cycles);
                    if (e.chk_alu) begin
                        chk("exec_alu_ctrl", ac, e.alu_ctrl);
                        chk("exec_alu_src", asrc, e.alu_src);
                    end
                    chk("pc_sel", bus.pc_sel, e.pc_sel);
                    chk("reg_write_cycles", regw, e.reg_writes);
                    if (e.reg_writes > 0) chk("wb_sel", wbs, e.wb_sel);
                    chk("dmem_req_cycles", dcyc, e.dmem_cycles);
                    if (e.dmem_cycles > 0) begin
                        chk("dmem_we", dwe, e.dmem_we);
                        chk("mem_alu_held", held_bad, 0);
                    end
                end
                active = 0; fetch = 0;
            end
        end
    end

    task automatic wait_drain(input int limit);
        bit done = 0;
        for (int k = 0; k < limit && !done; k++) begin
            @(negedge clk); #3;
            done = (prog.size() == 0 && exp_q.size() == 0);
        end
        chk("drain_before_timeout", done, 1);
    endtask

    task automatic trap_test(input logic [31:0] w);
        bit seen = 0;
        prog.push_back(mk(w, 0, 0, 0, 0));
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk); #3;
            seen = bus.illegal;
        end
        chk("trap_entered", seen, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #3;
            chk("trap_illegal_sticky", bus.illegal, 1);
            chk("trap_quiet", {bus.imem_req, bus.ir_write, bus.dmem_req, bus.reg_write, bus.pc_write}, 0);
        end
        rst = 1; #1;
        chk("trap_rst_clears_illegal", bus.illegal, 0);
        chk("trap_rst_imem_req", bus.imem_req, 0);
        @(negedge clk); #2 rst = 0; #1;
        chk("trap_resume_fetch", bus.imem_req, 1);
    endtask

    initial begin : main
        bit got = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_strobes", {bus.ir_write, bus.dmem_req, bus.reg_write, bus.pc_write, bus.pc_sel}, 0);
        chk("rst_alu_ctrl", bus.alu_ctrl, c_alu_add);
        chk("rst_alu_src_wb_sel", {bus.alu_src, bus.wb_sel}, 0);
        chk("rst_illegal", bus.illegal, 0);

        prog.push_back(mk(32'h002081B3, 0, 0, 0, 0));   // ADD x3,x1,x2
        prog.push_back(mk(32'h00208063, 1, 0, 0, 0));   // BEQ taken
        prog.push_back(mk(32'h00208063, 0, 0, 0, 0));   // BEQ not taken
        prog.push_back(mk(32'h0020F063, 0, 0, 0, 0));   // BGEU, lsb=0 -> taken
        prog.push_back(mk(32'h0000A183, 0, 0, 0, 3));   // LW, 3 wait states
        prog.push_back(mk(32'h0020A023, 0, 0, 0, 0));   // SW
        prog.push_back(mk(32'h0080006F, 0, 0, 0, 0));   // JAL
        prog.push_back(mk(32'h4020D1B3, 0, 0, 1, 0));   // SRA
        prog.push_back(mk(32'h40008193, 0, 0, 0, 0));   // ADDI with imm[10] set
        for (int i = 0; i < 60; i++) prog.push_back(rand_stim());

        @(negedge clk); #2 rst = 0; #1;
        chk("first_imem_req", bus.imem_req, 1);
        wait_drain(20000);

        trap_test(32'h0000007F);
        trap_test(32'h0020A063);                          // branch funct3=010

        prog.push_back(mk(32'h0000A183, 0, 0, 0, 60));
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); #2;
            got = bus.dmem_req;
        end
        chk("mem_reached", got, 1);
        rst = 1; #1;
        chk("rst_mid_mem_dmem_req", bus.dmem_req, 0);
        chk("rst_mid_mem_strobes", {bus.imem_req, bus.reg_write, bus.pc_write}, 0);
        for (int i = 0; i < 15; i++) prog.push_back(rand_stim());
        @(negedge clk); #2 rst = 0;
        wait_drain(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
